// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Round-robin sequencer for an external asynchronous SRAM shared by two
//   Avalon-MM-style requesters. Every SRAM-facing output is a flop, so the
//   strobes are glitch-free. The physical tri-state buffer lives one level up;
//   this block only supplies sram_dq_out / sram_dq_oe and samples sram_dq_in.
//
//   Transfer shape: IDLE (grant) -> SETUP -> ACCESS x WAIT -> DONE -> TURN x
//   TURNAROUND -> IDLE. A requester's waitrequest bit is low only in DONE.
//
// Optional feature (compile-time macro): SRAM_ARBITER_STATS_EN
//   defined   : contention_count counts stall cycles (saturating at 16'hFFFF)
//   undefined : contention_count is tied to 0
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   m_read/m_write       per-requester request bits (write wins if both set)
//   m_address            per-requester word address (slice i = requester i)
//   m_byteenable         per-requester active-high byte enables
//   m_writedata          per-requester write data
//   m_readdata           shared read-data register
//   m_waitrequest        per-requester wait, low in that requester's DONE
//   sram_csN/sram_cs     chip select (active low / active high CE2)
//   sram_oeN, sram_weN   output / write enable, active low
//   sram_beN             active-low byte enables
//   sram_addr            SRAM word address
//   sram_dq_out/_oe/_in  data bus toward / from the pad
//   contention_count     stall statistic
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2,
    parameter int TURNAROUND = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  m_read,
    input  logic [1:0]                  m_write,
    input  logic [2*ADDR_WIDTH-1:0]     m_address,
    input  logic [2*(DATA_WIDTH/8)-1:0] m_byteenable,
    input  logic [2*DATA_WIDTH-1:0]     m_writedata,
    output logic [DATA_WIDTH-1:0]       m_readdata,
    output logic [1:0]                  m_waitrequest,
    output logic                        sram_csN,
    output logic                        sram_cs,
    output logic                        sram_oeN,
    output logic                        sram_weN,
    output logic [DATA_WIDTH/8-1:0]     sram_beN,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic [DATA_WIDTH-1:0]       sram_dq_out,
    output logic                        sram_dq_oe,
    input  logic [DATA_WIDTH-1:0]       sram_dq_in,
    output logic [15:0]                 contention_count
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Wait counter only ever holds (N-1) for the longest of the three phases.
    localparam int MW1 = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int MW  = (MW1 > TURNAROUND) ? MW1 : TURNAROUND;
    localparam int CW  = (MW > 1) ? $clog2(MW) : 1;

    localparam logic [CW-1:0] RD_LOAD   = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD   = CW'(WRITE_WAIT - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_TURN
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_gnt;
    logic           r_is_wr;
    logic [CW-1:0]  r_cnt;

    // ------------------------------------------------------------------
    // Arbitration (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic [1:0]            w_act;
    logic                  w_any;
    logic                  w_sel;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_act = m_read | m_write;
    assign w_any = |w_act;

    always_comb begin
        w_sel = 1'b0;
        if (w_act == 2'b11)
            w_sel = ~r_last_grant;      // tie: whoever did not go last
        else
            w_sel = w_act[1];
    end

    assign w_wr    = m_write[w_sel];
    assign w_addr  = w_sel ? m_address[2*ADDR_WIDTH-1:ADDR_WIDTH]  : m_address[ADDR_WIDTH-1:0];
    assign w_be    = w_sel ? m_byteenable[2*BE_WIDTH-1:BE_WIDTH]   : m_byteenable[BE_WIDTH-1:0];
    assign w_wdata = w_sel ? m_writedata[2*DATA_WIDTH-1:DATA_WIDTH] : m_writedata[DATA_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Sequencer. Outputs are assigned on the edge that enters a state, so
    // each pin value lines up exactly with the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_gnt         <= 1'b0;
            r_is_wr       <= 1'b0;
            r_cnt         <= '0;
            m_readdata    <= '0;
            m_waitrequest <= 2'b11;
            sram_csN      <= 1'b1;
            sram_cs       <= 1'b0;
            sram_oeN      <= 1'b1;
            sram_weN      <= 1'b1;
            sram_beN      <= '1;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
        end else begin
            m_waitrequest <= 2'b11;
            case (r_state)
                S_IDLE: begin
                    sram_csN   <= 1'b1;
                    sram_cs    <= 1'b0;
                    sram_oeN   <= 1'b1;
                    sram_weN   <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_beN   <= '1;
                    if (w_any) begin
                        r_state      <= S_SETUP;
                        r_gnt        <= w_sel;
                        r_last_grant <= w_sel;
                        r_is_wr      <= w_wr;
                        sram_csN     <= 1'b0;
                        sram_cs      <= 1'b1;
                        sram_addr    <= w_addr;
                        sram_beN     <= ~w_be;
                        // Read: output enable from SETUP. Write: drive the bus
                        // one cycle ahead of weN so data is valid at its fall.
                        sram_oeN     <= w_wr;
                        sram_dq_oe   <= w_wr;
                        if (w_wr)
                            sram_dq_out <= w_wdata;
                    end
                end

                S_SETUP: begin
                    r_state  <= S_ACCESS;
                    r_cnt    <= r_is_wr ? WR_LOAD : RD_LOAD;
                    sram_weN <= ~r_is_wr;
                end

                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        sram_weN <= 1'b1;
                        sram_oeN <= 1'b1;
                        if (!r_is_wr)
                            m_readdata <= sram_dq_in;
                        m_waitrequest[r_gnt] <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    // csN and dq_oe were held through DONE for data hold time.
                    sram_csN   <= 1'b1;
                    sram_cs    <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_beN   <= '1;
                    if (TURNAROUND > 0) begin
                        r_state <= S_TURN;
                        r_cnt   <= TURN_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_TURN: begin
                    if (r_cnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Contention statistic
    // ------------------------------------------------------------------
`ifdef SRAM_ARBITER_STATS_EN
    logic [15:0] r_contention;
    logic        w_contend;

    // The non-owner is asking while the FSM is busy for the owner.
    assign w_contend = (r_state != S_IDLE) && w_act[~r_gnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_contention <= '0;
        else if (w_contend && (r_contention != 16'hFFFF))
            r_contention <= r_contention + 16'd1;
    end

    assign contention_count = r_contention;
`else
    assign contention_count = 16'd0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int BW = 2;
`ifdef SRAM_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        m_read, m_write;
    logic [2*AW-1:0]   m_address;
    logic [2*BW-1:0]   m_byteenable;
    logic [2*DW-1:0]   m_writedata;
    logic [DW-1:0]     m_readdata;
    logic [1:0]        m_waitrequest;
    logic              sram_csN, sram_cs, sram_oeN, sram_weN, sram_dq_oe;
    logic [BW-1:0]     sram_beN;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_dq_out, sram_dq_in;
    logic [15:0]       contention_count;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .sram_csN(sram_csN), .sram_cs(sram_cs), .sram_oeN(sram_oeN),
        .sram_weN(sram_weN), .sram_beN(sram_beN), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .contention_count(contention_count)
    );

    always #5 clk = ~clk;

    // Small SRAM model: low 8 address bits, byte-masked writes while weN low.
    logic [15:0] mem [0:255];
    assign sram_dq_in = (!sram_csN && !sram_oeN) ? mem[sram_addr[7:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (!sram_csN && !sram_weN) begin
            if (!sram_beN[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_beN[1]) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_bus_clash = 0;

    always @(negedge clk)
        if (!rst && sram_dq_oe && !sram_oeN) n_bus_clash++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start(input int r, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
        m_read[r]                = !wr;
        m_write[r]               = wr;
        m_address[r*AW +: AW]    = a;
        m_byteenable[r*BW +: BW] = be;
        m_writedata[r*DW +: DW]  = d;
    endtask

    task automatic stop(input int r);
        m_read[r]  = 1'b0;
        m_write[r] = 1'b0;
    endtask

    // Call at a negedge with the request already driven (cycle 0).
    // Samples each following cycle until requester r sees waitrequest low.
    task automatic run(input int r, input int drop_at,
                       output int done, output int we_lo, output int oe_lo,
                       output int dqoe_hi, output logic [1:0] be_seen,
                       output logic [15:0] rd);
        done = -1; we_lo = 0; oe_lo = 0; dqoe_hi = 0; be_seen = 2'b00; rd = 16'h0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!sram_weN)  we_lo++;
            if (!sram_oeN)  oe_lo++;
            if (sram_dq_oe) dqoe_hi++;
            if (!sram_csN)  be_seen = sram_beN;
            if (k == drop_at) stop(r);
            if (!m_waitrequest[r]) begin
                done = k;
                rd   = m_readdata;
                break;
            end
        end
    endtask

    int          done, we_lo, oe_lo, dqoe_hi, nd;
    logic [1:0]  be_seen;
    logic [15:0] rd, c0;

    initial begin
        rst = 1'b1;
        m_read = '0; m_write = '0; m_address = '0; m_byteenable = '0; m_writedata = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_csN",  sram_csN, 1);
        chk("rst_cs",   sram_cs, 0);
        chk("rst_oeN",  sram_oeN, 1);
        chk("rst_weN",  sram_weN, 1);
        chk("rst_beN",  sram_beN, 2'b11);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dqo",  sram_dq_out, 0);
        chk("rst_dqoe", sram_dq_oe, 0);
        chk("rst_rd",   m_readdata, 0);
        chk("rst_wait", m_waitrequest, 2'b11);
        chk("rst_cnt",  contention_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0xA5C3 to 0x10 from requester 0
        start(0, 1, 18'h00010, 2'b11, 16'hA5C3);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        chk("wr_done",  done, 4);
        chk("wr_weN",   we_lo, 2);
        chk("wr_dqoe",  dqoe_hi, 4);
        chk("wr_oeN",   oe_lo, 0);
        chk("wr_mem",   mem[8'h10], 16'hA5C3);
        repeat (2) @(negedge clk);

        // Read it back
        start(0, 0, 18'h00010, 2'b11, 16'h0);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        chk("rd_done", done, 4);
        chk("rd_data", rd, 16'hA5C3);
        chk("rd_oeN",  oe_lo, 3);
        chk("rd_dqoe", dqoe_hi, 0);
        chk("rd_weN",  we_lo, 0);
        repeat (2) @(negedge clk);

        // Preload: req0 -> addr1, then req1 -> addr2 (leaves last grant = 1)
        start(0, 1, 18'h00001, 2'b11, 16'h1111);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        repeat (2) @(negedge clk);
        start(1, 1, 18'h00002, 2'b11, 16'h2222);
        run(1, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(1);
        chk("wr1_done", done, 4);
        repeat (2) @(negedge clk);

        // Both read continuously: grants alternate 0,1,0,1 every 6 cycles
        c0 = contention_count;
        start(0, 0, 18'h00001, 2'b11, 16'h0);
        start(1, 0, 18'h00002, 2'b11, 16'h0);
        nd = 0;
        for (int k = 1; k <= 40 && nd < 4; k++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!m_waitrequest[r]) begin
                    chk($sformatf("alt_gnt%0d", nd), r, nd % 2);
                    chk($sformatf("alt_cyc%0d", nd), k, 4 + 6 * nd);
                    chk($sformatf("alt_rd%0d", nd), m_readdata, (r == 1) ? 16'h2222 : 16'h1111);
                    nd++;
                end
            end
        end
        chk("alt_n", nd, 4);
        stop(0);
        stop(1);
        @(negedge clk);
        // 5 stall cycles for each of the first three accesses, 3 for the last
        // (requests drop in its DONE cycle)
        chk("alt_contention", contention_count - c0, STATS ? 18 : 0);
        repeat (2) @(negedge clk);

        // Partial byte write: 0xFFFF then be=10 data 0x1234 -> 0x12FF
        start(1, 1, 18'h00020, 2'b11, 16'hFFFF);
        run(1, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(1);
        repeat (2) @(negedge clk);
        start(1, 1, 18'h00020, 2'b10, 16'h1234);
        run(1, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(1);
        chk("be_beN", be_seen, 2'b01);
        repeat (2) @(negedge clk);
        start(0, 0, 18'h00020, 2'b11, 16'h0);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        chk("be_rd", rd, 16'h12FF);
        repeat (2) @(negedge clk);

        // Zero byteenable: full cycle with beN all ones, memory untouched
        start(0, 1, 18'h00010, 2'b00, 16'h0000);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        chk("be0_done", done, 4);
        chk("be0_beN",  be_seen, 2'b11);
        chk("be0_we",   we_lo, 2);
        chk("be0_mem",  mem[8'h10], 16'hA5C3);
        repeat (2) @(negedge clk);

        // Requester 0 drops write after first ACCESS cycle; req1 queued at DONE
        start(0, 1, 18'h00030, 2'b11, 16'hBEEF);
        run(0, 2, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        chk("drop_done", done, 4);
        chk("drop_we",   we_lo, 2);
        start(1, 0, 18'h00030, 2'b11, 16'h0);
        // TURN (1), IDLE grant (2), SETUP (3), ACCESS x2, DONE at 6
        run(1, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(1);
        chk("drop_turn_done", done, 6);
        chk("drop_rd", rd, 16'hBEEF);
        repeat (2) @(negedge clk);

        // Reset during ACCESS of a write
        start(1, 1, 18'h00040, 2'b11, 16'h5555);
        @(negedge clk);               // SETUP
        @(negedge clk);               // ACCESS 1
        chk("pre_rst_weN", sram_weN, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_weN",  sram_weN, 1);
        chk("mid_rst_csN",  sram_csN, 1);
        chk("mid_rst_dqoe", sram_dq_oe, 0);
        chk("mid_rst_wait", m_waitrequest, 2'b11);
        @(negedge clk);
        stop(1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_csN",  sram_csN, 1);
        chk("post_rst_wait", m_waitrequest, 2'b11);
        chk("post_rst_cnt",  contention_count, 0);

        // First tie after reset goes to requester 0
        start(0, 0, 18'h00010, 2'b11, 16'h0);
        start(1, 0, 18'h00020, 2'b11, 16'h0);
        run(0, -1, done, we_lo, oe_lo, dqoe_hi, be_seen, rd);
        stop(0);
        stop(1);
        chk("tie_done", done, 4);
        chk("tie_rd",   rd, 16'hA5C3);
        repeat (4) @(negedge clk);

        chk("bus_clash", n_bus_clash, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the board's external asynchronous 16-bit SRAM (18-bit word address, byte enables) on behalf of two Avalon-MM-style requesters, e.g. the SOPC bridge and a local DMA/test engine.
- Arbitrates round-robin and generates registered, glitch-free chip-select, output-enable, write-enable and byte-enable strobes.
- The top level keeps the physical tri-state buffer for sram_dq.

Parameters:
- ADDR_WIDTH, 18: SRAM word-address width.
- DATA_WIDTH, 16: SRAM data width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8 (local).
- READ_WAIT, 2: ACCESS cycles for a read, minimum 1.
- WRITE_WAIT, 2: ACCESS cycles with sram_weN low, minimum 1.
- TURNAROUND, 1: idle bus cycles after each access, minimum 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_read  in  2  read request, bit i = requester i.
- m_write  in  2  write request, bit i = requester i.
- m_address  in  2*ADDR_WIDTH  word address; slice i = requester i.
- m_byteenable  in  2*BE_WIDTH  active-high byte enables per requester.
- m_writedata  in  2*DATA_WIDTH  write data per requester.
- m_readdata  out  DATA_WIDTH  shared read-data register.
- m_waitrequest  out  2  per-requester wait; low only in that requester's completion cycle.
- sram_csN  out  1  active-low chip select.
- sram_cs  out  1  active-high chip select (CE2).
- sram_oeN  out  1  active-low output enable.
- sram_weN  out  1  active-low write enable.
- sram_beN  out  BE_WIDTH  active-low byte enables.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_dq_out  out  DATA_WIDTH  write data toward the pad.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  DATA_WIDTH  data from the pad.
- contention_count  out  16  stall statistic (see Optional Feature).

Behaviour:
- Reset values:
  - sram_csN=1, sram_cs=0, sram_oeN=1, sram_weN=1, sram_beN='1, sram_addr=0.
  - sram_dq_out=0, sram_dq_oe=0, m_readdata=0, m_waitrequest=2'b11.
  - contention_count=0, last_grant=1, state=IDLE.
- All SRAM outputs come straight from flops; no combinational paths to pins.
- A requester is active when m_read|m_write. If both read and write are set, the write takes priority.
- Arbitration (IDLE only):
  - One active requester: grant it.
  - Both active: grant the one that is not last_grant. Requester 0 wins the first tie after reset.
  - On grant: latch address, byteenable, writedata and direction; update last_grant.
- FSM:
  - IDLE -> SETUP on grant.
  - SETUP (1 cycle): csN=0, cs=1, addr and beN driven. Read: oeN=0. Write: dq_oe=1, weN stays 1.
  - ACCESS (READ_WAIT or WRITE_WAIT cycles, wait counter): write holds weN=0; read holds oeN=0. On the last read ACCESS cycle, m_readdata <= sram_dq_in.
  - DONE (1 cycle): weN=1 and oeN=1. csN and dq_oe are held so data hold time is met. The granted requester's m_waitrequest bit goes low.
  - DONE -> TURN when TURNAROUND>0, otherwise DONE -> IDLE.
  - TURN (TURNAROUND cycles): chip deselected, dq_oe=0, then IDLE.
- Latency: the first sampled request cycle is IDLE at cycle 0. Completion (waitrequest low) is at cycle 2+WAIT. The next grant is possible at DONE+TURNAROUND+1.
- m_readdata stays stable until the next read capture.
- A requester that drops its request mid-transfer still has its SRAM cycle completed and pulsed. Its inputs are ignored after latching.
- A write with byteenable=0 still runs a full cycle with beN='1.
- sram_dq_oe is never 1 while sram_oeN=0.
- Reset asserted mid-access immediately returns every output to its reset value; the pending transfer is abandoned.
- Address wrap is not applicable: the address is passed through unmodified.

Optional Feature:
- Macro SRAM_ARBITER_STATS_EN.
- Defined: contention_count increments once per cycle in which a requester is active but the other requester owns the FSM (any non-IDLE state). It saturates at 16'hFFFF and clears only on rst.
- Undefined: contention_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then requester 0 writes addr=0x00010, data=0xA5C3, be=2'b11, with READ_WAIT=WRITE_WAIT=2 and TURNAROUND=1:
  - sram_weN is low for exactly 2 cycles; dq_oe=1 from SETUP through DONE.
  - m_waitrequest[0] is low in cycle 4.
- Read back 0x00010 through an SRAM model:
  - m_readdata=0xA5C3 in the cycle m_waitrequest[0]=0.
  - oeN is low for 3 cycles and dq_oe stays 0.
- Both requesters continuously read, at 0x00001 and 0x00002:
  - Grants alternate 0,1,0,1.
  - With SRAM_ARBITER_STATS_EN, contention_count increments by 4 per waiting access (SETUP+2 ACCESS+DONE) and per TURN cycle.
- Requester 1 writes be=2'b10, data=0x1234 over 0xFFFF:
  - sram_beN=2'b01 and the location reads back 0x12FF.
- Assert rst during ACCESS of a write:
  - sram_weN=1, csN=1, dq_oe=0 in the same cycle.
  - After release, the FSM is in IDLE, both waitrequest bits are 1, and the next tie grants requester 0.
- Requester 0 drops m_write after one ACCESS cycle:
  - The write still completes and the TURN cycle occurs before the next grant.
